// File: rtl/audio_pkg.sv
// Shared types, register map and bus FSM encoding for the audio sample queue.
package audio_pkg;

    typedef logic signed [15:0] sample_t;

    typedef enum logic [1:0] {
        BUS_IDLE,
        BUS_WAIT_SPACE,
        BUS_ACK,
        BUS_HOLD
    } bus_state_t;

    localparam logic [1:0] AUDIO_REG_DATA     = 2'd0;
    localparam logic [1:0] AUDIO_REG_STATUS   = 2'd1;
    localparam logic [1:0] AUDIO_REG_CONTROL  = 2'd2;
    localparam logic [1:0] AUDIO_REG_UNDERRUN = 2'd3;

    localparam int AUDIO_STATUS_FULL_BIT  = 31;
    localparam int AUDIO_STATUS_EMPTY_BIT = 30;
    localparam int AUDIO_CTRL_ENABLE_BIT  = 0;
    localparam int AUDIO_CTRL_FLUSH_BIT   = 1;

endpackage

// File: rtl/audio_sample_queue_mem.sv
// DEPTH x 16 simple dual-port sample RAM, synchronous write and synchronous read.
module audio_sample_queue_mem
    import audio_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          i_clock,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [15:0]   wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [15:0]   rd_data
);

    sample_t mem [DEPTH];

    always_ff @(posedge i_clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/audio_sample_queue.sv
// CPU-fed PCM sample FIFO feeding the PWM stage, with low-watermark interrupt.
// Optional saturating underrun counter: define AUDIO_SAMPLE_QUEUE_UNDERRUN_EN.
//
// state          | meaning
// BUS_IDLE       | waiting for i_request; decodes and performs the access
// BUS_WAIT_SPACE | DATA write to a full FIFO, pushes once a slot frees
// BUS_ACK        | o_ready high for exactly one cycle
// BUS_HOLD       | waiting for i_request to drop
module audio_sample_queue
    import audio_pkg::*;
#(
    parameter int DEPTH     = 1024,
    parameter int LOW_WATER = 256
) (
    input  logic        i_clock,
    input  logic        i_reset_n,
    input  logic        i_request,
    input  logic        i_rw,
    input  logic [1:0]  i_address,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_ready,
    output logic        o_interrupt,
    input  logic        i_output_busy,
    output logic [15:0] o_sample
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    bus_state_t    state, state_nxt;
    logic [AW-1:0] wr_ptr, rd_ptr, rd_addr_nxt;
    logic [CW-1:0] count;
    logic          enable, full, empty, consume, push, pop, flush, ctrl_wr;
    logic          byp_valid;
    sample_t       pend_data, push_data, byp_data, mem_q, head;
    logic [31:0]   rdata_nxt, status_word;
    logic [15:0]   underrun_val;
    logic          unused_wdata_hi;

    assign unused_wdata_hi = ^i_wdata[31:16];

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign consume = ~i_output_busy;
    assign flush   = (state == BUS_IDLE) && i_request && i_rw
                     && (i_address == AUDIO_REG_CONTROL) && i_wdata[AUDIO_CTRL_FLUSH_BIT];
    assign pop     = consume && enable && !empty && !flush;
    assign o_ready = (state == BUS_ACK);

    // Read address looks one cycle ahead so the registered RAM output is the head.
    assign rd_addr_nxt = flush ? wr_ptr : (rd_ptr + AW'(pop));
    assign head        = byp_valid ? byp_data : mem_q;

    always_comb begin
        status_word = '0;
        status_word[AUDIO_STATUS_FULL_BIT]  = full;
        status_word[AUDIO_STATUS_EMPTY_BIT] = empty;
        status_word[15:0] = 16'(count);
    end

    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        push_data = pend_data;
        ctrl_wr   = 1'b0;
        rdata_nxt = '0;
        unique case (state)
            BUS_IDLE: begin
                if (i_request) begin
                    state_nxt = BUS_ACK;
                    if (i_rw) begin
                        case (i_address)
                            AUDIO_REG_DATA: begin
                                if (full) begin
                                    state_nxt = BUS_WAIT_SPACE;
                                end else begin
                                    push      = 1'b1;
                                    push_data = i_wdata[15:0];
                                end
                            end
                            AUDIO_REG_CONTROL: ctrl_wr = 1'b1;
                            default: ;
                        endcase
                    end else begin
                        case (i_address)
                            AUDIO_REG_STATUS:   rdata_nxt = status_word;
                            AUDIO_REG_CONTROL:  rdata_nxt = {31'd0, enable};
                            AUDIO_REG_UNDERRUN: rdata_nxt = {16'd0, underrun_val};
                            default:            rdata_nxt = '0;
                        endcase
                    end
                end
            end
            BUS_WAIT_SPACE: begin
                if (pop || !full) begin
                    push      = 1'b1;
                    state_nxt = BUS_ACK;
                end
            end
            BUS_ACK:  state_nxt = BUS_HOLD;
            BUS_HOLD: begin
                if (!i_request) begin
                    state_nxt = BUS_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state       <= BUS_IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            enable      <= 1'b0;
            pend_data   <= '0;
            byp_valid   <= 1'b0;
            byp_data    <= '0;
            o_rdata     <= '0;
            o_sample    <= '0;
            o_interrupt <= 1'b0;
        end else begin
            state   <= state_nxt;
            o_rdata <= rdata_nxt;
            rd_ptr  <= rd_addr_nxt;
            if (state == BUS_IDLE && i_request) begin
                pend_data <= i_wdata[15:0];
            end
            if (ctrl_wr) begin
                enable <= i_wdata[AUDIO_CTRL_ENABLE_BIT];
            end
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (flush) begin
                count <= CW'(push);
            end else if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
            // A write landing on the address being read next is not yet visible in the RAM.
            byp_valid <= push && (wr_ptr == rd_addr_nxt);
            byp_data  <= push_data;
            if (flush || !enable) begin
                o_sample <= '0;
            end else if (consume) begin
                o_sample <= pop ? head : '0;
            end
            o_interrupt <= enable && (count <= CW'(LOW_WATER));
        end
    end

`ifdef AUDIO_SAMPLE_QUEUE_UNDERRUN_EN
    logic [15:0] underrun_cnt;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            underrun_cnt <= '0;
        end else if (flush) begin
            underrun_cnt <= '0;
        end else if (consume && enable && empty && (underrun_cnt != 16'hFFFF)) begin
            underrun_cnt <= underrun_cnt + 16'd1;
        end
    end

    assign underrun_val = underrun_cnt;
`else
    assign underrun_val = '0;
`endif

    audio_sample_queue_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .i_clock (i_clock),
        .wr_en   (push),
        .wr_addr (wr_ptr),
        .wr_data (push_data),
        .rd_addr (rd_addr_nxt),
        .rd_data (mem_q)
    );

endmodule

// File: tb/tb_audio_sample_queue.sv
// Self-checking bench for audio_sample_queue: register vector table plus sample scoreboard.
module tb_audio_sample_queue;
    import audio_pkg::*;

    localparam int DEPTH     = 1024;
    localparam int LOW_WATER = 256;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_request;
    logic        i_rw;
    logic [1:0]  i_address;
    logic [31:0] i_wdata;
    logic [31:0] o_rdata;
    logic        o_ready;
    logic        o_interrupt;
    logic        i_output_busy;
    logic [15:0] o_sample;

    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] sb_q[$];
    logic        model_en = 1'b0;

    typedef struct {
        logic        rw;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[13];

    audio_sample_queue #(.DEPTH(DEPTH), .LOW_WATER(LOW_WATER)) dut (
        .i_clock       (clk),
        .i_reset_n     (rst_n),
        .i_request     (i_request),
        .i_rw          (i_rw),
        .i_address     (i_address),
        .i_wdata       (i_wdata),
        .o_rdata       (o_rdata),
        .o_ready       (o_ready),
        .o_interrupt   (o_interrupt),
        .i_output_busy (i_output_busy),
        .o_sample      (o_sample)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bus_access(input logic rw, input logic [1:0] addr, input logic [31:0] wdata,
                              output logic [31:0] rdata);
        logic got;
        got = 1'b0;
        rdata = '0;
        i_request = 1'b1; i_rw = rw; i_address = addr; i_wdata = wdata;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (o_ready) begin
                got = 1'b1;
                rdata = o_rdata;
                break;
            end
        end
        if (!got) check("bus_ack_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        i_request = 1'b0;
        @(negedge clk);
        check("ready_one_cycle", {31'd0, o_ready}, 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic push_sample(input logic [15:0] s);
        logic [31:0] rd;
        bus_access(1'b1, AUDIO_REG_DATA, {16'hDEAD, s}, rd);
        sb_q.push_back(s);
    endtask

    task automatic read_check(input string name, input logic [1:0] addr, input logic [31:0] exp);
        logic [31:0] rd;
        bus_access(1'b0, addr, 32'd0, rd);
        check(name, rd, exp);
    endtask

    task automatic consume_check(input string name);
        logic [15:0] exp;
        exp = (model_en && sb_q.size() > 0) ? sb_q.pop_front() : 16'd0;
        i_output_busy = 1'b0;
        @(posedge clk); #1;
        i_output_busy = 1'b1;
        @(negedge clk);
        check(name, {16'd0, o_sample}, {16'd0, exp});
    endtask

    initial begin
        logic [31:0] rd;
        logic [15:0] exp_s;
        logic        got;
        int          exp_under;

        rst_n = 1'b0; i_request = 1'b0; i_rw = 1'b0; i_address = '0;
        i_wdata = '0; i_output_busy = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outputs", {o_rdata[15:0], o_sample},          32'd0);
        check("reset_flags",   {30'd0, o_ready, o_interrupt},       32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        vecs[0]  = '{1'b0, AUDIO_REG_STATUS,   32'd0,          32'h4000_0000};
        vecs[1]  = '{1'b0, AUDIO_REG_CONTROL,  32'd0,          32'd0};
        vecs[2]  = '{1'b0, AUDIO_REG_UNDERRUN, 32'd0,          32'd0};
        vecs[3]  = '{1'b1, AUDIO_REG_CONTROL,  32'd1,          32'd0};
        vecs[4]  = '{1'b0, AUDIO_REG_CONTROL,  32'd0,          32'd1};
        vecs[5]  = '{1'b1, AUDIO_REG_DATA,     32'h0000_1234,  32'd0};
        vecs[6]  = '{1'b1, AUDIO_REG_DATA,     32'hABCD_8000,  32'd0};
        vecs[7]  = '{1'b0, AUDIO_REG_STATUS,   32'd0,          32'h0000_0002};
        vecs[8]  = '{1'b0, AUDIO_REG_DATA,     32'd0,          32'd0};
        vecs[9]  = '{1'b1, AUDIO_REG_UNDERRUN, 32'h0000_FFFF,  32'd0};
        vecs[10] = '{1'b0, AUDIO_REG_UNDERRUN, 32'd0,          32'd0};
        vecs[11] = '{1'b1, AUDIO_REG_CONTROL,  32'h0000_0005,  32'd0};
        vecs[12] = '{1'b0, AUDIO_REG_CONTROL,  32'd0,          32'd1};
        for (int i = 0; i < 13; i++) begin
            bus_access(vecs[i].rw, vecs[i].addr, vecs[i].wdata, rd);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp);
            if (vecs[i].rw && vecs[i].addr == AUDIO_REG_DATA) sb_q.push_back(vecs[i].wdata[15:0]);
            if (vecs[i].rw && vecs[i].addr == AUDIO_REG_CONTROL) model_en = vecs[i].wdata[0];
        end

        consume_check("first_sample");
        read_check("status_count1", AUDIO_REG_STATUS, 32'h0000_0001);
        consume_check("second_sample");
        read_check("status_empty", AUDIO_REG_STATUS, 32'h4000_0000);

        for (int i = 0; i < 3; i++) consume_check("underrun_silence");
`ifdef AUDIO_SAMPLE_QUEUE_UNDERRUN_EN
        exp_under = 3;
`else
        exp_under = 0;
`endif
        read_check("underrun_count", AUDIO_REG_UNDERRUN, 32'(exp_under));
        bus_access(1'b1, AUDIO_REG_CONTROL, 32'd3, rd);
        read_check("underrun_flushed", AUDIO_REG_UNDERRUN, 32'd0);
        @(negedge clk);
        check("irq_empty", {31'd0, o_interrupt}, 32'd1);

        for (int i = 0; i < 5; i++) push_sample(16'(16'h0100 + i));
        i_request = 1'b1; i_rw = 1'b1; i_address = AUDIO_REG_DATA; i_wdata = 32'h0000_0A5A;
        i_output_busy = 1'b0;
        exp_s = sb_q.pop_front();
        sb_q.push_back(16'h0A5A);
        @(posedge clk); #1;
        i_output_busy = 1'b1;
        @(negedge clk);
        check("same_cycle_ready",  {31'd0, o_ready}, 32'd1);
        check("same_cycle_sample", {16'd0, o_sample}, {16'd0, exp_s});
        @(posedge clk); #1; i_request = 1'b0;
        @(posedge clk); #1;
        read_check("same_cycle_count", AUDIO_REG_STATUS, 32'h0000_0005);
        for (int i = 0; i < 5; i++) consume_check("same_cycle_order");

        for (int i = 0; i < LOW_WATER + 1; i++) push_sample(16'($urandom_range(0, 65535)));
        @(negedge clk);
        check("irq_above_lw", {31'd0, o_interrupt}, 32'd0);
        consume_check("lw_sample");
        check("irq_lag", {31'd0, o_interrupt}, 32'd0);
        @(posedge clk); #1;
        check("irq_at_lw", {31'd0, o_interrupt}, 32'd1);

        bus_access(1'b1, AUDIO_REG_CONTROL, 32'd3, rd);
        sb_q.delete();
        for (int i = 0; i < 11; i++) push_sample(16'(16'h7000 + i));
        consume_check("pre_flush_sample");
        i_request = 1'b1; i_rw = 1'b1; i_address = AUDIO_REG_CONTROL; i_wdata = 32'd3;
        i_output_busy = 1'b0;
        @(posedge clk); #1;
        i_output_busy = 1'b1;
        sb_q.delete();
        @(negedge clk);
        check("flush_sample", {16'd0, o_sample}, 32'd0);
        @(posedge clk); #1; i_request = 1'b0;
        @(posedge clk); #1;
        read_check("flush_count", AUDIO_REG_STATUS, 32'h4000_0000);

        for (int i = 0; i < DEPTH; i++) push_sample(16'(i * 7 + 3));
        read_check("full_status", AUDIO_REG_STATUS, 32'h8000_0400);
        i_request = 1'b1; i_rw = 1'b1; i_address = AUDIO_REG_DATA; i_wdata = 32'h0000_7777;
        got = 1'b0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            if (o_ready) got = 1'b1;
        end
        check("full_withheld", {31'd0, got}, 32'd0);
        exp_s = sb_q.pop_front();
        i_output_busy = 1'b0;
        @(posedge clk); #1;
        i_output_busy = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            if (o_ready) begin
                got = 1'b1;
                break;
            end
        end
        check("full_ack", {31'd0, got}, 32'd1);
        check("full_pop_sample", {16'd0, o_sample}, {16'd0, exp_s});
        sb_q.push_back(16'h7777);
        @(posedge clk); #1; i_request = 1'b0;
        @(posedge clk); #1;
        read_check("full_after_wait", AUDIO_REG_STATUS, 32'h8000_0400);

        i_request = 1'b1; i_rw = 1'b1; i_address = AUDIO_REG_DATA; i_wdata = 32'h0000_1111;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_outputs", {o_rdata[15:0], o_sample}, 32'd0);
        check("rst_mid_flags",   {30'd0, o_ready, o_interrupt}, 32'd0);
        i_request = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        sb_q.delete();
        model_en = 1'b0;
        got = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            if (o_ready || o_interrupt || o_sample != 16'd0) got = 1'b1;
        end
        check("rst_quiet", {31'd0, got}, 32'd0);
        read_check("rst_status",  AUDIO_REG_STATUS,  32'h4000_0000);
        read_check("rst_control", AUDIO_REG_CONTROL, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
